// File: rtl/assoc_cache.sv
// N-way set-associative write-back data cache, true-LRU, word-serial memory port.
// Optional hit/miss statistics are built when ASSOC_CACHE_STATS_EN is defined.
module assoc_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 256,
  parameter int WAYS           = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int WC_W    = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_SH = 2 + OFF_W;
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - IDX_W - LINE_SH;
  localparam int WAY_W   = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_valid [SETS][WAYS];
  logic                  r_dirty [SETS][WAYS];
  logic [WAY_W-1:0]      r_age   [SETS][WAYS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS][WORDS_PER_LINE];

  logic [WC_W-1:0]  r_word;
  logic [WAY_W-1:0] r_way;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_rtag;
  logic [TAG_W-1:0] r_vtag;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [WC_W-1:0]       w_word;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_found;
  logic [WAY_W-1:0]      w_vic_way;
  logic                  w_vic_dirty;
  logic                  w_idle;
  logic                  w_acc_hit;
  logic                  w_miss;
  logic                  w_st_we;
  logic                  w_last;
  logic                  w_fill_we;
  logic                  w_fill_done;
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic                  w_lru_en;
  logic [IDX_W-1:0]      w_lru_set;
  logic [WAY_W-1:0]      w_lru_way;
  logic [WAY_W-1:0]      w_lru_old;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_st_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [TAG_W-1:0]      w_ln_tag;
  logic [ADDR_WIDTH-1:0] w_maddr;

  assign w_idx  = cpu_addr[LINE_SH +: IDX_W];
  assign w_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_word = (OFF_W == 0) ? '0 : WC_W'(cpu_addr >> 2);

  // Tag compare across all ways of the addressed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way.
  always_comb begin
    w_found   = 1'b0;
    w_vic_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_found   = 1'b1;
        w_vic_way = WAY_W'(w);
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) begin
          w_vic_way = WAY_W'(w);
        end
      end
    end
  end

  assign w_vic_dirty = r_valid[w_idx][w_vic_way]
                     & r_dirty[w_idx][w_vic_way];

  assign w_idle      = (r_state == S_IDLE);
  assign w_acc_hit   = w_idle & cpu_req & w_hit;
  assign w_miss      = w_idle & cpu_req & ~w_hit;
  assign w_st_we     = w_acc_hit & cpu_we;
  assign w_last      = (r_word == WC_W'(WORDS_PER_LINE - 1));
  assign w_fill_we   = (r_state == S_REFILL) & mem_ack;
  assign w_fill_done = w_fill_we & w_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and memory-port strobes.
  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_next = w_vic_dirty ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        if (mem_ack && w_last) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        w_mem_req = 1'b1;
        if (mem_ack && w_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the miss context and step the word counter on each ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
      r_way  <= '0;
      r_idx  <= '0;
      r_rtag <= '0;
      r_vtag <= '0;
    end else if (w_miss) begin
      r_word <= '0;
      r_way  <= w_vic_way;
      r_idx  <= w_idx;
      r_rtag <= w_tag;
      r_vtag <= r_tag[w_idx][w_vic_way];
    end else if (w_mem_req && mem_ack) begin
      r_word <= w_last ? '0 : r_word + 1'b1;
    end
  end

  assign w_lru_en  = w_acc_hit | w_fill_done;
  assign w_lru_set = w_acc_hit ? w_idx : r_idx;
  assign w_lru_way = w_acc_hit ? w_hit_way : r_way;
  assign w_lru_old = r_age[w_lru_set][w_lru_way];

  // Line state: valid/dirty flags and LRU ages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      // The victim is dropped up front so an aborted fill never leaves it valid.
      if (w_miss) begin
        r_valid[w_idx][w_vic_way] <= 1'b0;
        r_dirty[w_idx][w_vic_way] <= 1'b0;
      end
      if (w_st_we) begin
        r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_fill_done) begin
        r_valid[r_idx][r_way] <= 1'b1;
        r_dirty[r_idx][r_way] <= 1'b0;
      end
      if (w_lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_lru_way) begin
            r_age[w_lru_set][w] <= '0;
          end else if (r_age[w_lru_set][w] < w_lru_old) begin
            r_age[w_lru_set][w] <= r_age[w_lru_set][w] + 1'b1;
          end
        end
      end
    end
  end

  // Tag and data storage: refill words, store merges, new tag on fill.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[r_idx][r_way][r_word] <= mem_rdata;
    end
    if (w_st_we) begin
      r_data[w_idx][w_hit_way][w_word] <= w_st_word;
    end
    if (w_fill_done) begin
      r_tag[r_idx][r_way] <= r_rtag;
    end
  end

  assign w_rword = r_data[w_idx][w_hit_way][w_word];

  // Load extraction and store lane merge.
  always_comb begin
    w_byte    = w_rword[{cpu_addr[1:0], 3'b000} +: 8];
    w_half    = w_rword[{cpu_addr[1], 4'b0000} +: 16];
    w_load    = w_rword;
    w_st_word = w_rword;
    unique case (cpu_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = w_rword;
    endcase
    unique case (cpu_funct3[1:0])
      2'b00:   w_st_word[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
      2'b01:   w_st_word[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
      default: w_st_word = cpu_wdata;
    endcase
  end

  assign w_ln_tag = (r_state == S_WB) ? r_vtag : r_rtag;
  assign w_maddr  = (ADDR_WIDTH'(w_ln_tag) << (IDX_W + LINE_SH))
                  | (ADDR_WIDTH'(r_idx) << LINE_SH)
                  | (ADDR_WIDTH'(r_word) << 2);

  assign cpu_ready = w_acc_hit;
  assign cpu_rdata = w_acc_hit ? w_load : '0;
  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_req ? w_maddr : '0;
  assign mem_wdata = w_mem_we ? r_data[r_idx][r_way][r_word] : '0;

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_acc_hit && (r_hits != '1)) begin
        r_hits <= r_hits + 1'b1;
      end
      if (w_miss && (r_misses != '1)) begin
        r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: recency-list cache model, flat memory image,
// directed scenarios with literal expectations and a randomized phase.
module tb_assoc_cache;

  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int WPL  = 4;
`ifdef ASSOC_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = 3'd0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic ack_en = 1'b1;
  bit   ack_rand = 1'b0;
  int   rd_acks = 0;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] bmem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit          dirty_m [int unsigned];
  int unsigned lines [$];
  xfer_t       exp_q [$];
  xfer_t       seen_q [$];
  int          m_hits = 0;
  int          m_miss = 0;

  assign mem_ack = mem_req & ack_en;

  always #5 clk = ~clk;

  assoc_cache #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SETS(SETS),
    .WAYS(WAYS),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bmem_rd(input int unsigned k);
    return bmem.exists(k) ? bmem[k] : 32'(k);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'(k);
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w,
      input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m;
    int sh;
    case (f3)
      3'd0: begin
        sh = 8 * a;
        m = 32'hFF << sh;
        return (old & ~m) | ((wd & 32'hFF) << sh);
      end
      3'd1: begin
        sh = a[1] ? 16 : 0;
        m = 32'hFFFF << sh;
        return (old & ~m) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic int find_line(input int unsigned ln);
    foreach (lines[i]) if (lines[i] == ln) return i;
    return -1;
  endfunction

  // Memory side: random ack gaps, read data, transfer log.
  always @(negedge clk) begin
    ack_en = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    mem_rdata = bmem_rd(mem_addr >> 2);
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      xfer_t t;
      t.we = mem_we;
      t.addr = mem_addr;
      t.data = mem_wdata;
      seen_q.push_back(t);
      if (mem_we) bmem[mem_addr >> 2] = mem_wdata;
      else rd_acks++;
    end
  end

  // Compare process: model-predicted outputs checked every cycle.
  always @(negedge clk) begin : cmp
    xfer_t t, e;
    int unsigned ln, v, key;
    int k, cnt, vi;
    if (reset) begin
      exp_q.delete();
      seen_q.delete();
      lines.delete();
      dirty_m.delete();
      ref_mem = bmem;
      m_hits = 0;
      m_miss = 0;
    end else begin
      chk("hit_count", hit_count, STATS ? 32'(m_hits) : 32'd0);
      chk("miss_count", miss_count, STATS ? 32'(m_miss) : 32'd0);
      while (seen_q.size() > 0) begin
        t = seen_q.pop_front();
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer_we", 32'(t.we), 32'(e.we));
          chk("xfer_addr", t.addr, e.addr);
          if (e.we) chk("xfer_wdata", t.data, e.data);
        end
      end
      if (exp_q.size() == 0) chk("mem_req_idle", 32'(mem_req), 32'd0);
      if (!cpu_req || exp_q.size() > 0) begin
        chk("ready_low", 32'(cpu_ready), 32'd0);
      end else begin
        ln = cpu_addr >> 4;
        key = cpu_addr >> 2;
        k = find_line(ln);
        if (k >= 0) begin
          chk("ready_hit", 32'(cpu_ready), 32'd1);
          if (!cpu_we) begin
            chk("load_data", cpu_rdata,
                ld_ext(ref_rd(key), cpu_funct3, cpu_addr[1:0]));
          end else begin
            ref_mem[key] = st_merge(ref_rd(key), cpu_wdata,
                                    cpu_funct3, cpu_addr[1:0]);
            dirty_m[ln] = 1'b1;
          end
          lines.delete(k);
          lines.push_front(ln);
          m_hits++;
        end else begin
          chk("ready_miss", 32'(cpu_ready), 32'd0);
          cnt = 0;
          vi = -1;
          foreach (lines[i]) begin
            if ((lines[i] % SETS) == (ln % SETS)) begin
              cnt++;
              vi = i;
            end
          end
          if (cnt == WAYS) begin
            v = lines[vi];
            if (dirty_m.exists(v) && dirty_m[v]) begin
              for (int w = 0; w < WPL; w++) begin
                e.we = 1'b1;
                e.addr = 32'(v * 16 + 4 * w);
                e.data = ref_rd(v * 4 + w);
                exp_q.push_back(e);
              end
            end
            lines.delete(vi);
            dirty_m.delete(v);
          end
          for (int w = 0; w < WPL; w++) begin
            e.we = 1'b0;
            e.addr = 32'(ln * 16 + 4 * w);
            e.data = '0;
            exp_q.push_back(e);
          end
          lines.push_front(ln);
          dirty_m[ln] = 1'b0;
          m_miss++;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output int lat);
    bit done;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_funct3 = f3;
    cpu_addr = a;
    cpu_wdata = wd;
    done = 1'b0;
    rd = '0;
    lat = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        done = 1'b1;
        rd = cpu_rdata;
        lat = i;
      end
    end
    chk("ready_wait", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    logic [31:0] rd;
    int lat;
    logic [2:0] f3;
    logic we;
    bit got;
    int base;
    logic [2:0] ldf [5];
    ldf[0] = 3'd0; ldf[1] = 3'd1; ldf[2] = 3'd2;
    ldf[3] = 3'd4; ldf[4] = 3'd5;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clk);
    #1;

    access(0, 3'd2, 32'h000, 0, rd, lat);
    chk("lw000_lat", 32'(lat), 32'd5);
    chk("lw000_data", rd, 32'h0);
    chk("lw000_misses", miss_count, STATS ? 32'd1 : 32'd0);
    access(0, 3'd2, 32'h008, 0, rd, lat);
    chk("lw008_lat", 32'(lat), 32'd0);
    chk("lw008_data", rd, 32'h2);
    access(1, 3'd2, 32'h008, 32'h0000_80FF, rd, lat);
    access(0, 3'd0, 32'h009, 0, rd, lat);
    chk("lb009", rd, 32'hFFFF_FF80);
    access(0, 3'd4, 32'h009, 0, rd, lat);
    chk("lbu009", rd, 32'h0000_0080);
    access(1, 3'd2, 32'h004, 32'hDEAD_BEEF, rd, lat);
    chk("sw004_lat", 32'(lat), 32'd0);
    access(0, 3'd2, 32'h040, 0, rd, lat);
    chk("lw040_lat", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h080, 0, rd, lat);
    chk("lw080_wb_lat", 32'(lat), 32'd9);
    chk("wb_word1", bmem_rd(1), 32'hDEAD_BEEF);
    chk("wb_word2", bmem_rd(2), 32'h0000_80FF);

    access(0, 3'd2, 32'h000, 0, rd, lat);
    chk("lru_a_lat", 32'(lat), 32'd5);
    chk("lru_a_data", rd, 32'h0);
    access(0, 3'd2, 32'h040, 0, rd, lat);
    chk("lru_b_lat", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h000, 0, rd, lat);
    chk("lru_c_lat", 32'(lat), 32'd0);
    access(0, 3'd2, 32'h080, 0, rd, lat);
    chk("lru_d_lat", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h000, 0, rd, lat);
    chk("lru_e_hit", 32'(lat), 32'd0);

    access(1, 3'd1, 32'h046, 32'h1234, rd, lat);
    chk("sh046_lat", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h044, 0, rd, lat);
    chk("sh046_word", rd, 32'h1234_0011);
    access(0, 3'd5, 32'h046, 0, rd, lat);
    chk("lhu046", rd, 32'h0000_1234);
    access(0, 3'd2, 32'h0C0, 0, rd, lat);
    chk("lw0c0_lat", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h080, 0, rd, lat);
    chk("sh_wb_lat", 32'(lat), 32'd9);
    chk("sh_wb_mem", bmem_rd(32'h11), 32'h1234_0011);

    ack_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 2) == 0);
      f3 = we ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
      access(we, f3, 32'($urandom_range(0, 255)), $urandom, rd, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    ack_rand = 1'b0;
    access(0, 3'd2, 32'h000, 0, rd, lat);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_funct3 = 3'd2;
    cpu_addr = 32'h1030;
    base = rd_acks;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rd_acks - base >= 1) got = 1'b1;
    end
    chk("mid_refill_wait", 32'(got), 32'd1);
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_ready", 32'(cpu_ready), 32'd0);
    chk("abort_hits", hit_count, 32'd0);
    chk("abort_misses", miss_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    access(0, 3'd2, 32'h000, 0, rd, lat);
    chk("post_rst_miss", 32'(lat), 32'd5);
    access(0, 3'd2, 32'h1030, 0, rd, lat);
    chk("partial_not_valid", 32'(lat), 32'd5);
    chk("partial_data", rd, 32'h0000_040C);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, true-LRU replacement and a handshaked word-serial memory port. Sits between the core's load/store stage and data memory, replacing the single-word 2-way cache. Hits complete combinationally in the request cycle. Misses stall the core via `cpu_ready` while an internal FSM writes back the dirty victim and refills the line.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; fixed at 32 for sub-word ops
- `SETS`, 256, number of sets; power of 2, ≥2
- `WAYS`, 4, associativity; power of 2, ≥2
- `WORDS_PER_LINE`, 4, words per line; power of 2, ≥1
- `clk`  in  1  clock. Reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset
- `cpu_req`  in  1  access valid
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_funct3`  in  3  RISC-V funct3: B/H/W/BU/HU
- `cpu_addr`  in  ADDR_WIDTH  byte address
- `cpu_wdata`  in  DATA_WIDTH  store data, right-aligned
- `cpu_rdata`  out  DATA_WIDTH  load data, extended per funct3
- `cpu_ready`  out  1  access completes this cycle
- `mem_req`  out  1  memory transfer valid
- `mem_we`  out  1  1 = writeback word, 0 = refill read
- `mem_addr`  out  ADDR_WIDTH  word-aligned address
- `mem_wdata`  out  DATA_WIDTH  writeback data
- `mem_rdata`  in  DATA_WIDTH  refill data, valid with `mem_ack`
- `mem_ack`  in  1  current word done
- `hit_count`, `miss_count`  out  32 each  statistics (see Configuration)

## Operation
- Address split: offset = low `2+log2(WORDS_PER_LINE)` bits (word select above bit 1), index = next `log2(SETS)` bits, tag = remainder.
- Per line: valid, dirty, tag, age (`log2(WAYS)` bits), data words.
- Hit = valid and tag match in any way. At most one way can match.
- Load hit: `cpu_rdata` is the selected word. LB/LH sign-extend, LBU/LHU zero-extend. Byte lane comes from `addr[1:0]`. Halfword lane comes from `addr[1]` only; `addr[0]` is ignored.
- Store hit: SB/SH/SW write the lane(s) at the clock edge and set the line dirty.
- LRU: on every hit and on refill completion, the accessed way's age becomes 0. Ways younger than its old age increment. Ages stay a permutation of 0..WAYS-1.
- Victim: the lowest-index invalid way. If all ways are valid, the way with age WAYS-1.
- FSM states:
  - IDLE → WRITEBACK on miss with dirty victim.
  - IDLE → REFILL on miss with clean or invalid victim.
  - WRITEBACK → REFILL after the last word is acked.
  - REFILL → IDLE after the last word is acked. The line is now valid and clean, with the new tag.
- After REFILL the core's held request is re-evaluated in IDLE and hits. Stores then merge and mark the line dirty (write-allocate).
- WRITEBACK: `mem_we`=1; `mem_addr` = {victim tag, index, word, 00}. Words go in order 0..WORDS_PER_LINE-1; the word counter advances on each `mem_ack`.
- REFILL: `mem_we`=0; same address order using the requested tag. `mem_rdata` is written into the line on each ack.
- `cpu_req`=0: no state change, `cpu_ready`=0.

## Timing
- Reset: all valid/dirty bits cleared, way w age = w, FSM IDLE, word counter 0. All outputs 0, including `cpu_rdata` and the counters.
- Hit latency is 0. `cpu_ready`=1 in the same cycle as `cpu_req`, and `cpu_rdata` is combinational.
- Miss latency is `W·2 + 1` cycles when dirty and `W + 1` when clean (W = WORDS_PER_LINE), assuming `mem_ack` every cycle. Each memory wait cycle adds one.
- Core rule: while `cpu_ready`=0, the core holds `cpu_req`, address, data and funct3 stable. Behaviour is undefined otherwise.
- Memory rule: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack`. `mem_req` stays high across consecutive words of one state. `mem_ack` with `mem_req`=0 is ignored.
- `cpu_ready`=0 in every non-IDLE state.
- Reset in mid-transfer: the FSM returns to IDLE and `mem_req` is 0 from the next cycle. Dirty data is discarded.
- A partial refill never leaves the line valid.

## Configuration
- `ASSOC_CACHE_STATS_EN` defined: `hit_count` increments on every IDLE cycle with `cpu_req` and a hit. `miss_count` increments on each IDLE→WRITEBACK/REFILL transition. Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter logic is generated.

## Test plan
Bench parameters: SETS=4, WAYS=2, WORDS_PER_LINE=4; memory holds word address>>2 at each location and acks every cycle.
- After reset, LW 0x000: REFILL reads 0x000–0x00C; `cpu_ready` rises 5 cycles after the request; `cpu_rdata`=0x0; `miss_count`=1.
- Then LW 0x008: same-cycle hit, `cpu_rdata`=0x2. LB 0x009 with the word set to 0x0000_80FF returns 0xFFFF_FF80 (byte 1 = 0x80, sign-extended); LBU 0x009 returns 0x0000_0080.
- SW 0x004 ← 0xDEADBEEF (hit, dirty). LW 0x040 fills way 1. LW 0x080 evicts way 0: WRITEBACK writes 0x000..0x00C with 0xDEADBEEF at 0x004; miss latency is 9 cycles.
- LRU check: LW 0x000, LW 0x040, LW 0x000, then LW 0x080 evicts the 0x040 line; a following LW 0x000 hits.
- SH 0x046 ← 0x1234 on miss: refill, then the line's word 1 = 0x1234_0011, dirty. Subsequent LHU 0x046 returns 0x0000_1234.
- Assert reset on the second REFILL word: `mem_req`=0 next cycle, all lookups miss, counters read 0.
